// File: rtl/ahb_boot_pkg.sv
// Shared constants for the AHB flash boot copier: FSM state codes,
// AHB-lite encodings and the flash window bounds.
package ahb_boot_pkg;

   // Boot copier FSM states
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_RD_ADDR = 3'd1;
   localparam logic [2:0] ST_RD_DATA = 3'd2;
   localparam logic [2:0] ST_WR_ADDR = 3'd3;
   localparam logic [2:0] ST_WR_DATA = 3'd4;
   localparam logic [2:0] ST_DONE    = 3'd5;
   localparam logic [2:0] ST_ERROR   = 3'd6;

   // AHB-lite encodings used by this master
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HSIZE_WORD    = 2'b10;
   localparam logic [1:0] HRESP_OKAY    = 2'b00;
   localparam logic [1:0] HRESP_ERROR   = 2'b01;

   // Flash window served by the downstream slave
   localparam logic [31:0] FLASH_BASE = 32'h1000_0000;
   localparam logic [31:0] FLASH_END  = 32'h1004_FFFF;

   // Next word address; wraps modulo 2^32 by construction
   function automatic logic [31:0] next_word(input logic [31:0] addr);
      return addr + 32'd4;
   endfunction

endpackage

// File: rtl/ahb_flash_boot_loader.sv
// AHB-lite boot copier: after reset, copies WORD_COUNT words from flash to
// SRAM one non-pipelined transfer at a time, sums the image, then releases
// the CPU reset. Any bus ERROR parks the block with the CPU held in reset.
//
// Handshake: an address phase is accepted on the clock edge where HREADY=1
// while HTRANS=NONSEQ; a data phase completes on the edge where HREADY=1 and
// HRESP=OKAY. HRESP=ERROR ends the data phase at its first cycle, regardless
// of HREADY. Only one transfer is ever outstanding.
module ahb_flash_boot_loader
   import ahb_boot_pkg::*;
#(
   parameter logic [31:0] SRC_BASE   = FLASH_BASE,
   parameter logic [31:0] DST_BASE   = 32'h2000_0000,
   parameter logic [15:0] WORD_COUNT = 16'd1024
) (
   input  logic        HCLK,
   input  logic        HRST_n,
   input  logic        boot_start,
   input  logic        boot_bypass,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [1:0]  HSIZE,
   output logic [31:0] HWDATA,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic [1:0]  HRESP,
   output logic        cpu_rst_n,
   output logic        boot_done,
   output logic        boot_err,
   output logic [31:0] boot_sum,
   output logic [15:0] word_cnt
);

   logic [2:0]  state_q, state_d;
   logic [31:0] src_q, src_d;
   logic [31:0] dst_q, dst_d;
   logic [31:0] data_q, data_d;
   logic [31:0] haddr_d, hwdata_d, sum_d;
   logic [1:0]  htrans_d;
   logic        hwrite_d;
   logic [15:0] cnt_d;
   logic        bus_err;
   logic        rd_done;
   logic        wr_done;

   assign bus_err = (HRESP == HRESP_ERROR);
   assign rd_done = (state_q == ST_RD_DATA) && HREADY && !bus_err;
   assign wr_done = (state_q == ST_WR_DATA) && HREADY && !bus_err;

   // The word size never changes, so HSIZE is a constant
   assign HSIZE = HSIZE_WORD;

   // State register
   always_ff @(posedge HCLK or negedge HRST_n) begin
      if (!HRST_n) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic: bypass beats start, ERROR beats HREADY in data phases
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (boot_bypass)                          state_d = ST_DONE;
            else if (boot_start && WORD_COUNT == 16'd0) state_d = ST_DONE;
            else if (boot_start)                      state_d = ST_RD_ADDR;
         end
         ST_RD_ADDR: if (HREADY) state_d = ST_RD_DATA;
         ST_RD_DATA: begin
            if (bus_err)     state_d = ST_ERROR;
            else if (HREADY) state_d = ST_WR_ADDR;
         end
         ST_WR_ADDR: if (HREADY) state_d = ST_WR_DATA;
         ST_WR_DATA: begin
            if (bus_err) state_d = ST_ERROR;
            else if (HREADY)
               state_d = (word_cnt + 16'd1 == WORD_COUNT) ? ST_DONE : ST_RD_ADDR;
         end
         ST_DONE:  state_d = ST_DONE;
         ST_ERROR: state_d = ST_ERROR;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output/datapath next values, decoded from the upcoming state so every
   // output register lines up with the state it belongs to
   always_comb begin
      src_d    = wr_done ? next_word(src_q) : src_q;
      dst_d    = wr_done ? next_word(dst_q) : dst_q;
      cnt_d    = wr_done ? word_cnt + 16'd1 : word_cnt;
      data_d   = rd_done ? HRDATA : data_q;
      sum_d    = rd_done ? boot_sum + HRDATA : boot_sum;
      hwdata_d = ((state_q == ST_WR_ADDR) && HREADY) ? data_q : HWDATA;
      haddr_d  = HADDR;
      htrans_d = HTRANS_IDLE;
      hwrite_d = (state_d == ST_WR_ADDR) || (state_d == ST_WR_DATA);
      if (state_d == ST_RD_ADDR) begin
         haddr_d  = src_d;
         htrans_d = HTRANS_NONSEQ;
      end else if (state_d == ST_WR_ADDR) begin
         haddr_d  = dst_d;
         htrans_d = HTRANS_NONSEQ;
      end
   end

   // Output, address, count and checksum registers
   always_ff @(posedge HCLK or negedge HRST_n) begin
      if (!HRST_n) begin
         HADDR     <= 32'h0;
         HTRANS    <= HTRANS_IDLE;
         HWRITE    <= 1'b0;
         HWDATA    <= 32'h0;
         cpu_rst_n <= 1'b0;
         boot_done <= 1'b0;
         boot_err  <= 1'b0;
         boot_sum  <= 32'h0;
         word_cnt  <= 16'h0;
         src_q     <= SRC_BASE;
         dst_q     <= DST_BASE;
         data_q    <= 32'h0;
      end else begin
         HADDR     <= haddr_d;
         HTRANS    <= htrans_d;
         HWRITE    <= hwrite_d;
         HWDATA    <= hwdata_d;
         cpu_rst_n <= (state_d == ST_DONE);
         boot_done <= (state_d == ST_DONE);
         boot_err  <= (state_d == ST_ERROR);
         boot_sum  <= sum_d;
         word_cnt  <= cnt_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         data_q    <= data_d;
      end
   end

endmodule

// File: tb/tb_ahb_flash_boot_loader.sv
// Bench for the boot copier: three copiers (4, 2 and 0 words) each face a
// behavioural flash/SRAM slave with configurable read wait states and an
// injectable ERROR response on a chosen read.
module tb_ahb_flash_boot_loader;
   import ahb_boot_pkg::*;

   localparam int NI = 3;
   localparam int MEMW = 16;
   localparam int LOGW = 64;
   localparam logic [31:0] SRC = 32'h1000_0000;
   localparam logic [31:0] DST = 32'h2000_0000;

   // Clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n  [NI];
   logic        start  [NI];
   logic        bypass [NI];
   logic [31:0] haddr  [NI];
   logic [1:0]  htrans [NI];
   logic        hwrite [NI];
   logic [1:0]  hsize  [NI];
   logic [31:0] hwdata [NI];
   logic [31:0] hrdata [NI];
   logic        hready [NI];
   logic [1:0]  hresp  [NI];
   logic        cpu_rst_n [NI];
   logic        done   [NI];
   logic        err    [NI];
   logic [31:0] sum    [NI];
   logic [15:0] wcnt   [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      ahb_flash_boot_loader #(
         .SRC_BASE  (SRC),
         .DST_BASE  (DST),
         .WORD_COUNT((g == 0) ? 16'd4 : (g == 1) ? 16'd2 : 16'd0)
      ) dut (
         .HCLK       (clk),
         .HRST_n     (rst_n[g]),
         .boot_start (start[g]),
         .boot_bypass(bypass[g]),
         .HADDR      (haddr[g]),
         .HTRANS     (htrans[g]),
         .HWRITE     (hwrite[g]),
         .HSIZE      (hsize[g]),
         .HWDATA     (hwdata[g]),
         .HRDATA     (hrdata[g]),
         .HREADY     (hready[g]),
         .HRESP      (hresp[g]),
         .cpu_rst_n  (cpu_rst_n[g]),
         .boot_done  (done[g]),
         .boot_err   (err[g]),
         .boot_sum   (sum[g]),
         .word_cnt   (wcnt[g])
      );
   end

   // Slave model state
   logic [31:0] flash [NI][MEMW];
   logic [31:0] sram  [NI][MEMW];
   int          wait_cfg [NI];
   int          err_rd   [NI];
   logic        pend     [NI];
   logic        pend_wr  [NI];
   logic [31:0] pend_addr[NI];
   int          wait_ctr [NI];
   int          rd_cnt   [NI];
   logic        err_stage[NI];
   logic [31:0] log_addr [NI][LOGW];
   int          log_n     [NI] = '{default: 0};
   int          nonseq_cnt[NI] = '{default: 0};
   int          stall_bad [NI] = '{default: 0};

   int n_checks = 0;
   int n_err = 0;

   function automatic int widx(input logic [31:0] a, input logic [31:0] base);
      logic [31:0] d;
      d = a - base;
      return int'(d[5:2]);
   endfunction

   // Slave response: reads stall wait_cfg cycles; the chosen read answers ERROR
   always_comb begin
      for (int k = 0; k < NI; k++) begin
         hready[k] = 1'b1;
         hresp[k]  = HRESP_OKAY;
         hrdata[k] = 32'h0;
         if (pend[k] && !pend_wr[k]) begin
            hrdata[k] = flash[k][widx(pend_addr[k], SRC)];
            if (err_rd[k] != 0 && rd_cnt[k] == err_rd[k]) begin
               hresp[k]  = HRESP_ERROR;
               hready[k] = err_stage[k];
            end else begin
               hready[k] = (wait_ctr[k] == 0);
            end
         end
      end
   end

   // Slave sequencing, SRAM writes and bus monitors
   always @(posedge clk) begin
      for (int k = 0; k < NI; k++) begin
         if (!rst_n[k]) begin
            pend[k]      <= 1'b0;
            pend_wr[k]   <= 1'b0;
            rd_cnt[k]    <= 0;
            wait_ctr[k]  <= 0;
            err_stage[k] <= 1'b0;
         end else begin
            if (pend[k] && !hready[k]) begin
               if (hresp[k] == HRESP_ERROR) err_stage[k] <= 1'b1;
               else                         wait_ctr[k] <= wait_ctr[k] - 1;
               if (htrans[k] != HTRANS_IDLE || haddr[k] != pend_addr[k])
                  stall_bad[k] <= stall_bad[k] + 1;
            end
            if (pend[k] && hready[k] && pend_wr[k])
               sram[k][widx(pend_addr[k], DST)] <= hwdata[k];
            if (hready[k]) begin
               err_stage[k] <= 1'b0;
               if (htrans[k] == HTRANS_NONSEQ) begin
                  pend[k]      <= 1'b1;
                  pend_wr[k]   <= hwrite[k];
                  pend_addr[k] <= haddr[k];
                  wait_ctr[k]  <= hwrite[k] ? 0 : wait_cfg[k];
                  if (!hwrite[k]) rd_cnt[k] <= rd_cnt[k] + 1;
                  log_addr[k][log_n[k] % LOGW] <= haddr[k];
                  log_n[k]      <= log_n[k] + 1;
                  nonseq_cnt[k] <= nonseq_cnt[k] + 1;
               end else begin
                  pend[k] <= 1'b0;
               end
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input int k, input string pfx);
      check({pfx, "_haddr"},  haddr[k], 32'h0);
      check({pfx, "_htrans"}, 32'(htrans[k]), 32'(HTRANS_IDLE));
      check({pfx, "_hwrite"}, 32'(hwrite[k]), 32'd0);
      check({pfx, "_hsize"},  32'(hsize[k]), 32'(HSIZE_WORD));
      check({pfx, "_hwdata"}, hwdata[k], 32'h0);
      check({pfx, "_cpu_rst_n"}, 32'(cpu_rst_n[k]), 32'd0);
      check({pfx, "_done"},   32'(done[k]), 32'd0);
      check({pfx, "_err"},    32'(err[k]), 32'd0);
      check({pfx, "_sum"},    sum[k], 32'h0);
      check({pfx, "_wcnt"},   32'(wcnt[k]), 32'd0);
   endtask

   // Reset held across two rising edges so the slave model clears too
   task automatic do_reset(input int k);
      @(negedge clk);
      rst_n[k] = 1'b0;
      start[k] = 1'b0;
      bypass[k] = 1'b0;
      repeat (2) @(negedge clk);
      rst_n[k] = 1'b1;
   endtask

   // Start a copy; cycles counts edges from leaving IDLE to done/err
   task automatic run_copy(input int k, output int cycles);
      @(negedge clk);
      start[k] = 1'b1;
      @(posedge clk);
      #1;
      cycles = 0;
      while (!(done[k] || err[k]) && cycles < 2000) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      check("copy_finished", 32'(done[k] | err[k]), 32'd1);
   endtask

   function automatic logic [31:0] exp_sum(input int k, input int n);
      logic [31:0] s = 32'h0;
      for (int i = 0; i < n; i++) s += flash[k][i];
      return s;
   endfunction

   // Expected bus order: read src word i, then write dst word i
   task automatic check_addr_log(input int k, input int base, input int n_words);
      logic [31:0] exp_q[$];
      logic [31:0] e;
      for (int i = 0; i < n_words; i++) begin
         exp_q.push_back(SRC + 32'(4 * i));
         exp_q.push_back(DST + 32'(4 * i));
      end
      check("addr_count", 32'(log_n[k] - base), 32'(exp_q.size()));
      for (int j = 0; exp_q.size() > 0; j++) begin
         e = exp_q.pop_front();
         check($sformatf("addr%0d", j), log_addr[k][(base + j) % LOGW], e);
      end
   endtask

   task automatic check_copy(input int k, input int n, input string pfx);
      check({pfx, "_done"}, 32'(done[k]), 32'd1);
      check({pfx, "_cpu_rst_n"}, 32'(cpu_rst_n[k]), 32'd1);
      check({pfx, "_err"}, 32'(err[k]), 32'd0);
      check({pfx, "_sum"}, sum[k], exp_sum(k, n));
      check({pfx, "_wcnt"}, 32'(wcnt[k]), 32'(n));
      for (int i = 0; i < n; i++)
         check($sformatf("%s_sram%0d", pfx, i), sram[k][i], flash[k][i]);
   endtask

   initial begin
      int cyc;
      int base;
      int snap;
      int w;
      for (int k = 0; k < NI; k++) begin
         rst_n[k] = 1'b0;
         start[k] = 1'b0;
         bypass[k] = 1'b0;
         wait_cfg[k] = 0;
         err_rd[k] = 0;
         for (int i = 0; i < MEMW; i++) flash[k][i] = 32'h0;
      end
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs(0, "rst");
      @(negedge clk);
      for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("idle_htrans", 32'(htrans[0]), 32'(HTRANS_IDLE));
      check("idle_cpu_rst_n", 32'(cpu_rst_n[0]), 32'd0);

      // Four words 1..4, zero wait states
      for (int i = 0; i < 4; i++) flash[0][i] = 32'(i + 1);
      base = log_n[0];
      run_copy(0, cyc);
      check("t1_cycles", 32'(cyc), 32'd16);
      check("t1_sum10", sum[0], 32'd10);
      check_copy(0, 4, "t1");
      check_addr_log(0, base, 4);

      // Random image with random read wait states
      do_reset(0);
      #1;
      check("t2_sum_cleared", sum[0], 32'h0);
      for (int i = 0; i < 4; i++) flash[0][i] = $urandom;
      w = $urandom_range(1, 3);
      wait_cfg[0] = w;
      base = log_n[0];
      run_copy(0, cyc);
      check("t2_cycles", 32'(cyc), 32'(4 * (4 + w)));
      check_copy(0, 4, "t2");
      check_addr_log(0, base, 4);
      wait_cfg[0] = 0;

      // Two words with 20-cycle read stalls
      do_reset(1);
      for (int i = 0; i < 2; i++) flash[1][i] = $urandom;
      wait_cfg[1] = 20;
      snap = stall_bad[1];
      run_copy(1, cyc);
      check("t3_cycles", 32'(cyc), 32'd48);
      check("t3_stall_stable", 32'(stall_bad[1] - snap), 32'd0);
      check_copy(1, 2, "t3");

      // ERROR on the third read data phase
      do_reset(0);
      for (int i = 0; i < 4; i++) flash[0][i] = $urandom;
      err_rd[0] = 3;
      run_copy(0, cyc);
      check("t4_err", 32'(err[0]), 32'd1);
      check("t4_wcnt", 32'(wcnt[0]), 32'd2);
      check("t4_cpu_rst_n", 32'(cpu_rst_n[0]), 32'd0);
      check("t4_done", 32'(done[0]), 32'd0);
      check("t4_sum", sum[0], exp_sum(0, 2));
      snap = nonseq_cnt[0];
      repeat (10) @(posedge clk);
      #1;
      check("t4_htrans_idle", 32'(htrans[0]), 32'(HTRANS_IDLE));
      check("t4_no_more_xfers", 32'(nonseq_cnt[0] - snap), 32'd0);
      check("t4_err_sticky", 32'(err[0]), 32'd1);
      err_rd[0] = 0;

      // Bypass together with start
      do_reset(0);
      snap = nonseq_cnt[0];
      @(negedge clk);
      start[0] = 1'b1;
      bypass[0] = 1'b1;
      @(posedge clk);
      #1;
      check("t5_done", 32'(done[0]), 32'd1);
      check("t5_cpu_rst_n", 32'(cpu_rst_n[0]), 32'd1);
      repeat (5) @(posedge clk);
      #1;
      check("t5_no_xfers", 32'(nonseq_cnt[0] - snap), 32'd0);
      check("t5_wcnt", 32'(wcnt[0]), 32'd0);
      bypass[0] = 1'b0;

      // Reset pulse during the write data phase of word 3
      do_reset(0);
      for (int i = 0; i < 4; i++) flash[0][i] = $urandom;
      @(negedge clk);
      start[0] = 1'b1;
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
      end while (!(wcnt[0] == 16'd2 && hwrite[0] && htrans[0] == HTRANS_IDLE) && cyc < 200);
      check("t6_reached_wr_data3", 32'(cyc < 200), 32'd1);
      #2;
      rst_n[0] = 1'b0;
      start[0] = 1'b0;
      #1;
      check_reset_outputs(0, "t6_async");
      repeat (2) @(negedge clk);
      rst_n[0] = 1'b1;
      base = log_n[0];
      run_copy(0, cyc);
      check("t6_restart_addr", log_addr[0][base % LOGW], SRC);
      check_copy(0, 4, "t6");
      check_addr_log(0, base, 4);

      // Zero-length image
      do_reset(2);
      snap = nonseq_cnt[2];
      run_copy(2, cyc);
      check("t7_cycles", 32'(cyc), 32'd0);
      check("t7_done", 32'(done[2]), 32'd1);
      check("t7_cpu_rst_n", 32'(cpu_rst_n[2]), 32'd1);
      check("t7_sum", sum[2], 32'h0);
      repeat (4) @(posedge clk);
      #1;
      check("t7_no_xfers", 32'(nonseq_cnt[2] - snap), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
